// File: rtl/nand_sweep_checker.sv
// Sweeps the shared 4-bit drive code through all 16 values and checks the 7 B-block
// responses against a built-in golden table, reporting pass/fail, error count and first failure.
module nand_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [3:0] V,
  input  logic [6:0] RESP,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FIRST_ERR,
  output logic [6:0] FAIL_RESP
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_t;

  // With no settle time the HOLD state is skipped entirely, so its exit value is unused then.
  localparam bit         NO_HOLD   = (SETTLE == 0);
  localparam logic [3:0] HOLD_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [6:0] golden;

  always_comb begin
    golden = 7'h00;
    case (V)
      4'h0: golden = 7'h6C;
      4'h1: golden = 7'h66;
      4'h2: golden = 7'h6E;
      4'h3: golden = 7'h49;
      4'h4: golden = 7'h48;
      4'h5: golden = 7'h44;
      4'h6: golden = 7'h4C;
      4'h7: golden = 7'h4C;
      4'h8: golden = 7'h46;
      4'h9: golden = 7'h64;
      4'hA: golden = 7'h64;
      4'hB: golden = 7'h62;
      4'hC: golden = 7'h59;
      4'hD: golden = 7'h4D;
      4'hE: golden = 7'h4C;
      4'hF: golden = 7'h5C;
      default: golden = 7'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      V         <= 4'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= 5'd0;
      FIRST_ERR <= 4'd0;
      FAIL_RESP <= 7'd0;
    end else begin
      DONE <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            V         <= 4'd0;
            BUSY      <= 1'b1;
            ERR_CNT   <= 5'd0;
            FIRST_ERR <= 4'd0;
            FAIL_RESP <= 7'd0;
            PASS      <= 1'b0;
            cnt_reg   <= 4'd0;
            state_reg <= NO_HOLD ? SAMPLE : HOLD;
          end
        end
        HOLD: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == HOLD_LAST) begin
            state_reg <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (RESP != golden) begin
            ERR_CNT <= ERR_CNT + 5'd1;
            if (ERR_CNT == 5'd0) begin
              FIRST_ERR <= V;
              FAIL_RESP <= RESP;
            end
          end
          // The sweep ends at F, so V never wraps back to 0 mid-sweep.
          if (V == 4'hF) begin
            state_reg <= FIN;
          end else begin
            V         <= V + 4'd1;
            cnt_reg   <= 4'd0;
            state_reg <= NO_HOLD ? SAMPLE : HOLD;
          end
        end
        FIN: begin
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          PASS      <= (ERR_CNT == 5'd0);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Three checker builds (SETTLE = 1, 0, 3) driven by shared START/RST_N, each with its own
// faultable RESP path, compared every cycle against a timeline model of the sweep.
module tb_nand_sweep_checker;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic START = 1'b0;

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] v;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic [3:0] first;
    logic [6:0] fail;
  } outs_t;

  logic [6:0] golden_rom [16] = '{7'h6C, 7'h66, 7'h6E, 7'h49, 7'h48, 7'h44, 7'h4C, 7'h4C,
                                  7'h46, 7'h64, 7'h64, 7'h62, 7'h59, 7'h4D, 7'h4C, 7'h5C};

  // Per-instance fault injection: RESP = ((golden & and_m) | or_m) ^ (V==fc ? fx : 0)
  logic [6:0] and_m [3] = '{7'h7F, 7'h7F, 7'h7F};
  logic [6:0] or_m  [3] = '{7'h00, 7'h00, 7'h00};
  logic [3:0] fc    [3] = '{4'h0, 4'h0, 4'h0};
  logic [6:0] fx    [3] = '{7'h00, 7'h00, 7'h00};

  function automatic logic [6:0] resp_of(input logic [3:0] c, input int i);
    return ((golden_rom[c] & and_m[i]) | or_m[i]) ^ ((c == fc[i]) ? fx[i] : 7'h00);
  endfunction

  // Expected outputs d edges after the accepting edge: code n is sampled at edge (n+1)(s+1),
  // results land at edge 16(s+1)+1 together with DONE.
  function automatic outs_t sweep_state(input int d, input int s, input int i);
    outs_t      o;
    int         nd;
    logic [6:0] r;
    o  = '0;
    nd = d / (s + 1);
    if (nd > 16) nd = 16;
    o.v    = (nd > 15) ? 4'hF : 4'(nd);
    o.busy = (d < 16 * (s + 1) + 1);
    for (int c = 0; c < nd; c++) begin
      r = resp_of(4'(c), i);
      if (r != golden_rom[c]) begin
        if (o.err == 5'd0) begin
          o.first = 4'(c);
          o.fail  = r;
        end
        o.err = o.err + 5'd1;
      end
    end
    if (d == 16 * (s + 1) + 1) begin
      o.done = 1'b1;
      o.pass = (o.err == 5'd0);
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int S = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    localparam int L = 16 * (S + 1) + 1;

    logic [3:0] v;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] first_err;
    logic [6:0] fail_resp;
    logic [6:0] resp;

    assign resp = ((golden_rom[v] & and_m[gi]) | or_m[gi]) ^ ((v == fc[gi]) ? fx[gi] : 7'h00);

    nand_sweep_checker #(.SETTLE(S)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .V         (v),
      .RESP      (resp),
      .BUSY      (busy),
      .DONE      (done),
      .PASS      (pass),
      .ERR_CNT   (err_cnt),
      .FIRST_ERR (first_err),
      .FAIL_RESP (fail_resp)
    );

    int    mc    = 0;
    int    k     = 0;
    bit    in_sw = 1'b0;
    outs_t e     = '0;

    always @(posedge CLK) begin
      mc <= mc + 1;
      if (!RST_N) begin
        in_sw <= 1'b0;
        e     <= '0;
      end else if (in_sw) begin
        e <= sweep_state(mc - k, S, gi);
        if (mc - k == L) in_sw <= 1'b0;
      end else if (START) begin
        in_sw <= 1'b1;
        k     <= mc;
        e     <= sweep_state(0, S, gi);
      end else begin
        e.done <= 1'b0;
      end
    end

    always @(negedge CLK) begin
      if (mc > 0) begin
        chk($sformatf("s%0d.v", S),         int'(v),         int'(e.v));
        chk($sformatf("s%0d.busy", S),      int'(busy),      int'(e.busy));
        chk($sformatf("s%0d.done", S),      int'(done),      int'(e.done));
        chk($sformatf("s%0d.pass", S),      int'(pass),      int'(e.pass));
        chk($sformatf("s%0d.err_cnt", S),   int'(err_cnt),   int'(e.err));
        chk($sformatf("s%0d.first_err", S), int'(first_err), int'(e.first));
        chk($sformatf("s%0d.fail_resp", S), int'(fail_resp), int'(e.fail));
      end
    end
  end

  task automatic maybe_fault(input int i, input bit active);
    int r;
    if (!active && $urandom_range(0, 3) == 0) begin
      and_m[i] = 7'h7F;
      or_m[i]  = 7'h00;
      fc[i]    = 4'h0;
      fx[i]    = 7'h00;
      r = $urandom_range(0, 3);
      case (r)
        1: and_m[i] = ~(7'h01 << $urandom_range(0, 6));
        2: or_m[i]  = 7'h01 << $urandom_range(0, 6);
        3: begin
          fc[i] = 4'($urandom_range(0, 15));
          fx[i] = 7'($urandom_range(1, 127));
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    int  l0, l1, l2;
    bit  seen;

    // Reset values
    RST_N = 1'b0;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_v",         int'(g[0].v),         0);
    chk("rst_busy",      int'(g[0].busy),      0);
    chk("rst_done",      int'(g[0].done),      0);
    chk("rst_pass",      int'(g[0].pass),      0);
    chk("rst_err_cnt",   int'(g[0].err_cnt),   0);
    chk("rst_first_err", int'(g[0].first_err), 0);
    chk("rst_fail_resp", int'(g[0].fail_resp), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Golden wiring: latency per build and a mid-sweep V value
    l0 = 0; l1 = 0; l2 = 0;
    START = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge CLK);
      START = 1'b0;
      if (g[0].done && l0 == 0) l0 = t;
      if (g[1].done && l1 == 0) l1 = t;
      if (g[2].done && l2 == 0) l2 = t;
      if (t == 20) chk("lit_v_edge20", int'(g[0].v), 10);
    end
    chk("lit_latency_s1", l0, 33);
    chk("lit_latency_s0", l1, 17);
    chk("lit_latency_s3", l2, 65);
    chk("lit_golden_pass_s1", int'(g[0].pass), 1);
    chk("lit_golden_err_s1",  int'(g[0].err_cnt), 0);
    chk("lit_golden_pass_s0", int'(g[1].pass), 1);
    chk("lit_golden_pass_s3", int'(g[2].pass), 1);
    chk("lit_v_holds_f",      int'(g[0].v), 15);

    // B3 stuck at 0
    and_m[0] = 7'h6F;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("lit_b3_err",   int'(g[0].err_cnt),   2);
    chk("lit_b3_first", int'(g[0].first_err), 12);
    chk("lit_b3_fail",  int'(g[0].fail_resp), 'h49);
    chk("lit_b3_pass",  int'(g[0].pass),      0);

    // RESP tied to 7F: all 16 vectors fail, counter must not wrap
    and_m[0] = 7'h7F;
    or_m[0]  = 7'h7F;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("lit_7f_err",   int'(g[0].err_cnt),   16);
    chk("lit_7f_first", int'(g[0].first_err), 0);
    chk("lit_7f_fail",  int'(g[0].fail_resp), 'h7F);
    chk("lit_7f_pass",  int'(g[0].pass),      0);
    or_m[0] = 7'h00;
    repeat (70) @(negedge CLK);

    // Reset in the middle of a sweep, then a clean sweep
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("lit_midrst_v",    int'(g[0].v),       0);
    chk("lit_midrst_busy", int'(g[0].busy),    0);
    chk("lit_midrst_busy3", int'(g[2].busy),   0);
    RST_N = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (40) @(negedge CLK);
    chk("lit_after_rst_pass", int'(g[0].pass),    1);
    chk("lit_after_rst_err",  int'(g[0].err_cnt), 0);
    repeat (70) @(negedge CLK);

    // START held high: a new sweep begins right after the DONE pulse
    START = 1'b1;
    seen  = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge CLK);
      if (g[0].done) seen = 1'b1;
    end
    chk("lit_held_done_seen", int'(seen), 1);
    @(negedge CLK);
    chk("lit_held_busy_again", int'(g[0].busy), 1);
    chk("lit_held_v_restart",  int'(g[0].v),    0);
    repeat (50) @(negedge CLK);
    START = 1'b0;

    // Random traffic: START noise, occasional reset, faults changed only between sweeps
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      START = ($urandom_range(0, 3) == 0);
      RST_N = ($urandom_range(0, 299) != 0);
      maybe_fault(0, g[0].in_sw);
      maybe_fault(1, g[1].in_sw);
      maybe_fault(2, g[2].in_sw);
    end
    RST_N = 1'b1;
    START = 1'b0;
    repeat (5) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nand_sweep_checker.md
# nand_sweep_checker

Sequential stimulus-and-check engine for the 4-input NAND-implemented function blocks B1–B7. It drives the shared 4-bit input bus through all 16 codes and captures the 7 function outputs after a programmable settle time. Each captured word is compared against a built-in golden table, and the block reports pass/fail, error count and the first failing vector. It sits on the driving side of the B-block interface and turns the combinational lab circuits into a self-checking unit.

## Interface
- SETTLE, default 1: extra cycles each vector is held before RESP is sampled; legal range 0..15.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  sweep request; sampled only in IDLE.
- V  out  4  drive code; V[3]=I1 (MSB) … V[0]=I4; feeds I1..I4 of B1..B7.
- RESP  in  7  captured outputs; RESP[6]=B1, RESP[5]=B2 … RESP[0]=B7.
- BUSY  out  1  high from sweep accept through the last sample.
- DONE  out  1  one-cycle pulse when results become valid.
- PASS  out  1  1 when ERR_CNT=0 at end of sweep.
- ERR_CNT  out  5  number of mismatching vectors, 0..16.
- FIRST_ERR  out  4  lowest failing code; 0 if none failed.
- FAIL_RESP  out  7  RESP captured at FIRST_ERR; 0 if none failed.

## Operation
- Golden table, code → expected RESP in hex:
  - 0→6C, 1→66, 2→6E, 3→49
  - 4→48, 5→44, 6→4C, 7→4C
  - 8→46, 9→64, A→64, B→62
  - C→59, D→4D, E→4C, F→5C
- The golden table is a constant ROM inside the block; it is not a parameter.
- FSM states: IDLE, HOLD, SAMPLE, FIN.
- IDLE:
  - On START=1: V←0, BUSY←1, ERR_CNT←0, FIRST_ERR←0, FAIL_RESP←0, PASS←0, settle counter←0.
  - Then go to HOLD, or straight to SAMPLE when SETTLE=0.
- HOLD:
  - Settle counter increments each cycle.
  - When the counter equals SETTLE−1, go to SAMPLE.
- SAMPLE (one cycle):
  - Compare RESP with golden[V].
  - On mismatch: ERR_CNT+1. If this is the first error of the sweep, FIRST_ERR←V and FAIL_RESP←RESP.
  - If V=F: go to FIN.
  - Otherwise: V←V+1, counter←0, go to HOLD (or stay in SAMPLE when SETTLE=0).
- FIN (one cycle):
  - DONE=1, BUSY←0, PASS←(ERR_CNT==0).
  - Go to IDLE.
- Results (PASS, ERR_CNT, FIRST_ERR, FAIL_RESP) hold until the next accepted START. V holds F after a sweep.
- START is ignored in HOLD, SAMPLE and FIN. A START held high continuously starts a new sweep on the first IDLE cycle after FIN.
- ERR_CNT is 5 bits so that 16 errors do not wrap. The V increment never wraps inside a sweep, because the sweep ends at F.
- RST_N=0 in any state, including mid-sweep:
  - Next edge: state=IDLE and every output = 0.
  - Partial results are discarded.

## Timing
- Reset values: V=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR=0, FAIL_RESP=0.
- START accepted at edge k: BUSY=1 and V=0 are visible from edge k.
- Each code is presented for SETTLE+1 cycles.
- Code n is sampled at edge k+(n+1)(SETTLE+1).
- DONE is high for exactly one cycle, after edge k+16(SETTLE+1)+1.
- BUSY falls at the same edge DONE rises.
- Sweep-accept-to-DONE latency: 16(SETTLE+1)+1 cycles.
- RESP is treated as combinational from V. The DUT path must settle within SETTLE+1 cycles.

## Test plan
- B1..B7 wired to V/RESP, SETTLE=1, START pulsed at edge k → DONE after edge k+33; PASS=1, ERR_CNT=0, FIRST_ERR=0, FAIL_RESP=00; V sequences 0..F, each held 2 cycles.
- Same wiring with RESP[4] (B3) forced 0 → ERR_CNT=2, FIRST_ERR=C, FAIL_RESP=49, PASS=0.
- RESP tied to 7F → ERR_CNT=16 (no wrap), FIRST_ERR=0, FAIL_RESP=7F, PASS=0.
- SETTLE=0 and SETTLE=3 builds, golden wiring → DONE after edge k+17 and k+65 respectively; PASS=1 in both.
- RST_N low for one cycle at edge k+10 of a sweep → all outputs 0 at the next edge, state IDLE; a later START runs a complete sweep with PASS=1.
- START held high through a full sweep with golden wiring → BUSY rises again on the cycle after the DONE pulse; START pulses during BUSY have no effect on V sequencing.
